// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    S_COUNT = 3'd0,
    S_DATA  = 3'd1,
    S_CHECK = 3'd2,
    S_DONE  = 3'd3,
    S_ERROR = 3'd4
  } ld_state_t;

  localparam int DEPTH_DEFAULT  = 64;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte-to-word assembler for the boot loader; flags the 4th byte of each word.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  din,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  cnt;
  logic [23:0] sr;

  // The three held bytes plus the live 4th byte form the word, so no extra cycle is spent.
  assign word_valid = en && (cnt == 2'(BYTES_PER_WORD - 1));
  assign word       = {din, sr};

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
      sr  <= '0;
    end else if (en) begin
      cnt <= cnt + 2'd1;
      sr  <= {din, sr[23:8]};
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: writes a length-prefixed byte image into instruction RAM, then releases the core.
// Optional trailing checksum byte enabled by defining IMEM_LOADER_CHECKSUM_EN.
//
// state   | meaning
// COUNT   | waiting for the word-count byte
// DATA    | assembling and writing data words
// CHECK   | waiting for the trailing checksum byte (checksum build only)
// DONE    | image loaded, core released
// ERROR   | image rejected, core held in reset
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          we,
  output logic [AW-1:0] waddr,
  output logic [31:0]   wdata,
  output logic          cpu_reset,
  output logic          done,
  output logic          error
);

  ld_state_t     state;
  logic [AW-1:0] wcnt;
  logic [AW-1:0] last_idx;
  logic          xfer;
  logic          word_valid;
  logic [31:0]   word;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]    sum;
`endif

  assign in_ready = (state == S_COUNT) || (state == S_DATA) || (state == S_CHECK);
  assign xfer     = in_valid && in_ready;

  byte_packer u_packer (
    .clk        (clk),
    .clr        (reset || (state == S_COUNT)),
    .en         (xfer && (state == S_DATA)),
    .din        (in_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_COUNT;
      we        <= 1'b0;
      waddr     <= '0;
      wdata     <= '0;
      cpu_reset <= 1'b1;
      done      <= 1'b0;
      error     <= 1'b0;
      wcnt      <= '0;
      last_idx  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum       <= '0;
`endif
    end else begin
      we <= 1'b0;
      case (state)
        S_COUNT: begin
          if (xfer) begin
            if ((in_data == 8'd0) || (int'(in_data) > DEPTH)) begin
              state <= S_ERROR;
              error <= 1'b1;
            end else begin
              state    <= S_DATA;
              wcnt     <= '0;
              last_idx <= AW'(in_data - 8'd1);
`ifdef IMEM_LOADER_CHECKSUM_EN
              sum      <= in_data;
`endif
            end
          end
        end
        S_DATA: begin
          if (xfer) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum <= sum + in_data;
`endif
            if (word_valid) begin
              we    <= 1'b1;
              waddr <= wcnt;
              wdata <= word;
              wcnt  <= wcnt + 1'b1;
              if (wcnt == last_idx) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                state <= S_CHECK;
`else
                state <= S_DONE;
`endif
              end
            end
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (xfer) begin
            if (8'(sum + in_data) == 8'd0) begin
              state     <= S_DONE;
              done      <= 1'b1;
              cpu_reset <= 1'b0;
            end else begin
              state <= S_ERROR;
              error <= 1'b1;
            end
          end
        end
`endif
        // Release is registered one edge after entry so the last word commits first.
        S_DONE: begin
          done      <= 1'b1;
          cpu_reset <= 1'b0;
        end
        S_ERROR: begin
          error     <= 1'b1;
          cpu_reset <= 1'b1;
        end
        default: state <= S_COUNT;
      endcase
    end
  end

endmodule
